// File: rtl/spi_flash_pkg.sv
// SPI flash responder shared types and opcodes.
// Opcode constants are shared with the boot controller.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYCLES  = 8;

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// Pin synchronizers for sclk/csb/mosi plus edge pulses.
// csb synchronizes to the deselected (high) level out of reset.
module spi_pin_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic sclk_i,
  input  logic csb_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic csb_o,
  output logic csb_fall_o,
  output logic csb_rise_o,
  output logic mosi_o
);

  logic [SYNC_STG-1:0] sclk_q;
  logic [SYNC_STG-1:0] csb_q;
  logic [SYNC_STG-1:0] mosi_q;
  logic                sclk_prev_q;
  logic                csb_prev_q;

  // synchronizer chains and one extra stage for edge detection
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      sclk_q      <= '0;
      csb_q       <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STG-2:0], sclk_i};
      csb_q       <= {csb_q[SYNC_STG-2:0], csb_i};
      mosi_q      <= {mosi_q[SYNC_STG-2:0], mosi_i};
      sclk_prev_q <= sclk_q[SYNC_STG-1];
      csb_prev_q  <= csb_q[SYNC_STG-1];
    end
  end

  assign sclk_rise_o = sclk_q[SYNC_STG-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STG-1] & sclk_prev_q;
  assign csb_o       = csb_q[SYNC_STG-1];
  assign csb_fall_o  = ~csb_q[SYNC_STG-1] & csb_prev_q;
  assign csb_rise_o  = csb_q[SYNC_STG-1] & ~csb_prev_q;
  assign mosi_o      = mosi_q[SYNC_STG-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ (0x03) streaming from byte memory.
// Define SPI_FLASH_RESP_FAST_READ_EN to accept FAST READ (0x0B).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int SYNC_STG = 2
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              spi_sclk_i,
  input  logic              spi_csb_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  logic rise, fall, csb_s, csb_fall, csb_rise, mosi_s;

  spi_pin_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .sclk_i      (spi_sclk_i),
    .csb_i       (spi_csb_i),
    .mosi_i      (spi_mosi_i),
    .sclk_rise_o (rise),
    .sclk_fall_o (fall),
    .csb_o       (csb_s),
    .csb_fall_o  (csb_fall),
    .csb_rise_o  (csb_rise),
    .mosi_o      (mosi_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        nxt_q, nxt_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              ld_q, ld_d;
  logic              first_q, first_d;
  logic              skip_q, skip_d;
  logic              err_q, err_d;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
  logic              fast_q, fast_d;
`endif
  logic [7:0]        cmd_sh;
  logic [ADDR_W-1:0] addr_sh;

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      nxt_q      <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_q       <= 1'b0;
      maddr_q    <= '0;
      ld_q       <= 1'b0;
      first_q    <= 1'b0;
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      nxt_q      <= nxt_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rd_q       <= rd_d;
      maddr_q    <= maddr_d;
      ld_q       <= ld_d;
      first_q    <= first_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_q     <= fast_d;
`endif
    end
  end

  // next-state, shifting, fetch and MISO drive
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    nxt_d      = nxt_q;
    miso_d     = miso_q;
    rd_d       = 1'b0;
    maddr_d    = maddr_q;
    ld_d       = rd_q;
    first_d    = first_q;
    skip_d     = skip_q;
    err_d      = 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    fast_d     = fast_q;
`endif
    cmd_sh     = {rx_q[6:0], mosi_s};
    addr_sh    = {addr_q[ADDR_W-2:0], mosi_s};

    // first byte goes straight to MISO; later bytes wait in nxt
    if (ld_q) begin
      if (first_q) begin
        miso_d  = mem_data_i[7];
        tx_d    = {mem_data_i[6:0], 1'b0};
        first_d = 1'b0;
      end else begin
        nxt_d = mem_data_i;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (rise) begin
          rx_d      = cmd_sh;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            addr_d     = '0;
            if (cmd_sh == CMD_READ) begin
              state_d = ST_ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            end else if (cmd_sh == CMD_FAST_READ) begin
              state_d = ST_ADDR;
              fast_d  = 1'b1;
`endif
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
      end
      ST_ADDR: begin
        if (rise) begin
          addr_d    = addr_sh;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
          if (bit_cnt_q == 3'd7 && byte_cnt_q == 2'd2) begin
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            if (fast_q) begin
              state_d = ST_DUMMY;
            end else begin
`endif
              state_d = ST_DATA;
              rd_d    = 1'b1;
              maddr_d = addr_sh;
              addr_d  = addr_sh + 1'b1;
              first_d = 1'b1;
              skip_d  = 1'b1;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            end
`endif
          end
        end
      end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      ST_DUMMY: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DUMMY_CYCLES - 1)) begin
            state_d = ST_DATA;
            rd_d    = 1'b1;
            maddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
            first_d = 1'b1;
            skip_d  = 1'b1;
          end
        end
      end
`endif
      ST_DATA: begin
        if (fall) begin
          if (skip_q) begin
            // bit 7 of byte 0 is already out; just prefetch
            skip_d  = 1'b0;
            rd_d    = 1'b1;
            maddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
          end else if (bit_cnt_q == 3'd7) begin
            miso_d    = nxt_q[7];
            tx_d      = {nxt_q[6:0], 1'b0};
            bit_cnt_d = '0;
            rd_d      = 1'b1;
            maddr_d   = addr_q;
            addr_d    = addr_q + 1'b1;
          end else begin
            miso_d    = tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_IGNORE: begin
      end
      default: begin
      end
    endcase

    // deselect aborts everything, including in-flight reads
    if (csb_s || csb_rise) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      rx_d       = '0;
      tx_d       = '0;
      nxt_d      = '0;
      miso_d     = 1'b0;
      rd_d       = 1'b0;
      ld_d       = 1'b0;
      first_d    = 1'b0;
      skip_d     = 1'b0;
      err_d      = 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_d     = 1'b0;
`endif
    end

    oe_d = (state_d == ST_DATA);
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign mem_rd_o      = rd_q;
  assign mem_addr_o    = maddr_q;
  assign busy_o        = ~csb_s;
  assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized scoreboard bench for spi_flash_responder.
// Honours SPI_FLASH_RESP_FAST_READ_EN for the 0x0B expectation.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

`ifdef SPI_FLASH_RESP_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int HALF = 5;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        spi_sclk_i;
  logic        spi_csb_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        spi_miso_oe_o;
  logic        mem_rd_o;
  logic [23:0] mem_addr_o;
  logic [7:0]  mem_data_i = 8'h00;
  logic        busy_o;
  logic        cmd_err_o;

  spi_flash_responder dut (
    .clk_i         (clk_i),
    .reset_n       (reset_n),
    .spi_sclk_i    (spi_sclk_i),
    .spi_csb_i     (spi_csb_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .mem_rd_o      (mem_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .busy_o        (busy_o),
    .cmd_err_o     (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_byte_q[$];
  logic [23:0] exp_addr_q[$];
  bit          in_data = 1'b0;
  int          rd_cnt  = 0;
  int          err_cnt = 0;
  int          oe_cnt  = 0;

  function automatic logic [7:0] mem_fn(input logic [23:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'h11;
    return lo ^ a[15:8] ^ a[23:16];
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // backing memory: data one cycle after the strobe, noise otherwise
  always @(posedge clk_i)
    mem_data_i <= mem_rd_o ? mem_fn(mem_addr_o) : 8'($urandom);

  // read-strobe monitor: every read must match the next expected address
  always @(negedge clk_i) begin
    if (mem_rd_o) begin
      rd_cnt++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_rd", {8'h0, mem_addr_o}, 32'hFFFF_FFFF);
      end else begin
        chk("rd_addr", {8'h0, mem_addr_o}, {8'h0, exp_addr_q.pop_front()});
      end
    end
    if (cmd_err_o) err_cnt++;
    if (spi_miso_oe_o) oe_cnt++;
  end

  // MISO monitor: assemble bytes at SCLK rises and score them
  logic [7:0] mon_sh;
  int         mon_bits;
  bit         mon_was;
  initial begin
    mon_was  = 1'b0;
    mon_bits = 0;
    mon_sh   = '0;
  end
  always @(posedge spi_sclk_i) begin
    if (in_data) begin
      if (!mon_was) mon_bits = 0;
      mon_sh = {mon_sh[6:0], spi_miso_o};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_byte_q.size() == 0)
          chk("extra_byte", {24'h0, mon_sh}, 32'hFFFF_FFFF);
        else
          chk("miso_byte", {24'h0, mon_sh}, {24'h0, exp_byte_q.pop_front()});
      end
    end
    mon_was = in_data;
  end

  task automatic sclk_bit(input logic b);
    spi_mosi_i = b;
    repeat (HALF) @(posedge clk_i);
    #1 spi_sclk_i = 1'b1;
    repeat (HALF) @(posedge clk_i);
    #1 spi_sclk_i = 1'b0;
  endtask

  // one CSB frame; abort_bits>0 raises CSB after that many SCLKs
  task automatic xfer(input logic [7:0] op, input logic [23:0] a,
                      input int nbytes, input int abort_bits);
    bit sup, ok;
    int ndum, nb, rd0, err0, oe0;
    logic b;
    sup  = (op == CMD_READ) || (FAST && op == CMD_FAST_READ);
    ndum = (FAST && op == CMD_FAST_READ) ? 8 : 0;
    ok   = sup && (abort_bits == 0);
    nb   = (abort_bits > 0) ? abort_bits : 32 + ndum + 8 * nbytes;
    if (ok) begin
      for (int k = 0; k < nbytes; k++) exp_byte_q.push_back(mem_fn(a + 24'(k)));
      for (int k = 0; k < nbytes + 2; k++) exp_addr_q.push_back(a + 24'(k));
    end
    rd0 = rd_cnt; err0 = err_cnt; oe0 = oe_cnt;
    @(posedge clk_i);
    #1 spi_csb_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 chk("busy_hi", {31'h0, busy_o}, 32'h1);
    for (int i = 0; i < nb; i++) begin
      if (i < 8) b = op[7 - i];
      else if (i < 32) b = a[31 - i];
      else b = 1'($urandom);
      if (ok && i == 32 + ndum) in_data = 1'b1;
      sclk_bit(b);
    end
    in_data = 1'b0;
    repeat (HALF) @(posedge clk_i);
    #1 spi_csb_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("oe_lo_after", {31'h0, spi_miso_oe_o}, 32'h0);
    chk("busy_lo_after", {31'h0, busy_o}, 32'h0);
    chk("err_pulses", err_cnt - err0, (!sup && abort_bits == 0) ? 1 : 0);
    if (ok) begin
      chk("rd_enough", {31'h0, (rd_cnt - rd0) >= nbytes}, 32'h1);
      chk("rd_bounded", {31'h0, (rd_cnt - rd0) <= nbytes + 2}, 32'h1);
      chk("bytes_left", exp_byte_q.size(), 0);
    end else begin
      chk("no_rd", rd_cnt - rd0, 0);
      chk("no_oe", oe_cnt - oe0, 0);
    end
    exp_addr_q.delete();
    exp_byte_q.delete();
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] op;
    reset_n    = 1'b0;
    spi_csb_i  = 1'b0;
    spi_sclk_i = 1'b0;
    spi_mosi_i = 1'b0;
    // reset with CSB low and SCLK toggling
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(posedge clk_i);
      #1 spi_sclk_i = ~spi_sclk_i;
      spi_mosi_i = 1'($urandom);
      @(negedge clk_i);
      chk("reset_outs", {mem_addr_o, spi_miso_o, spi_miso_oe_o, mem_rd_o,
                         busy_o, cmd_err_o}, 32'h0);
    end
    spi_sclk_i = 1'b0;
    spi_csb_i  = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 chk("post_reset", {mem_addr_o, spi_miso_o, spi_miso_oe_o, mem_rd_o,
                          busy_o, cmd_err_o}, 32'h0);

    xfer(CMD_READ, 24'h000000, 8, 0);
    xfer(8'hA5, 24'h123456, 2, 0);
    xfer(CMD_READ, 24'hFFFFFE, 4, 0);
    xfer(CMD_READ, 24'h0000AA, 2, 8 + 13);
    xfer(CMD_READ, 24'h000010, 3, 0);
    xfer(CMD_FAST_READ, 24'h000004, 2, 0);
    for (int r = 0; r < 6; r++)
      xfer(CMD_READ, 24'($urandom), int'($urandom_range(1, 5)), 0);
    for (int r = 0; r < 3; r++) begin
      op = 8'($urandom);
      if (op == CMD_READ || op == CMD_FAST_READ) op = 8'h5A;
      xfer(op, 24'($urandom), 1, 0);
    end
    xfer(CMD_READ, 24'($urandom), 1, int'($urandom_range(9, 30)));
    xfer(CMD_READ, 24'hFFFFFF, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
